// File: rtl/tomasulo_core.sv
// Tomasulo out-of-order core: fixed program ROM, 8x8-bit register file with
// tag table, 3 add and 2 mul reservation stations. The adder and the
// multiplier are non-pipelined, and each broadcasts its result on its own CDB.
module tomasulo_core #(
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 4,
    parameter int PROG_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] clock_count,
    output logic [7:0] Op1,
    output logic [7:0] Op2,
    output logic [7:0] Op3,
    output logic [7:0] Op4,
    output logic [2:0] count,
    output logic [2:0] count2,
    output logic       ADD_Status,
    output logic [7:0] ADD_Output,
    output logic [2:0] ADD_Tag_op,
    output logic       MUL_Status,
    output logic [7:0] MUL_Output,
    output logic [2:0] MUL_Tag_op
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    // Program ROM; anything past the program reads as HALT.
    function automatic logic [10:0] rom_read(input logic [3:0] pc);
        logic [10:0] ins;
        case (pc)
            4'd0:    ins = {OP_ADD, 3'd1, 3'd2, 3'd3};
            4'd1:    ins = {OP_MUL, 3'd4, 3'd1, 3'd5};
            4'd2:    ins = {OP_SUB, 3'd6, 3'd7, 3'd2};
            4'd3:    ins = {OP_MUL, 3'd0, 3'd4, 3'd2};
            default: ins = {OP_HALT, 9'd0};
        endcase
        if (int'(pc) >= PROG_LEN) ins = {OP_HALT, 9'd0};
        return ins;
    endfunction

    // Source operand at issue: register value, or a CDB value broadcast this
    // cycle, otherwise the producer tag. Returns {tag, value}.
    function automatic logic [10:0] resolve(
        input logic [2:0] tag, input logic [7:0] rv,
        input logic as, input logic [2:0] at, input logic [7:0] av,
        input logic ms, input logic [2:0] mt, input logic [7:0] mv);
        logic [10:0] r;
        if (tag == 3'd0)            r = {3'd0, rv};
        else if (as && at == tag)   r = {3'd0, av};
        else if (ms && mt == tag)   r = {3'd0, mv};
        else                        r = {tag, 8'd0};
        return r;
    endfunction

    function automatic logic [7:0] alu(input logic sub, input logic [7:0] a, input logic [7:0] b);
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        return p[7:0];
    endfunction

    logic [4:0] r_clk_cnt;
    logic [3:0] r_pc;
    logic [7:0] r_regs [8];
    logic [2:0] r_rtag [8];

    logic [2:0] r_a_busy, r_a_exec, r_a_sub;
    logic [7:0] r_a_vj [3];
    logic [7:0] r_a_vk [3];
    logic [2:0] r_a_qj [3];
    logic [2:0] r_a_qk [3];

    logic [1:0] r_m_busy, r_m_exec;
    logic [7:0] r_m_vj [2];
    logic [7:0] r_m_vk [2];
    logic [2:0] r_m_qj [2];
    logic [2:0] r_m_qk [2];

    logic       r_au_busy, r_mu_busy;
    logic [3:0] r_au_left, r_mu_left;
    logic [1:0] r_au_idx;
    logic       r_mu_idx;
    logic [7:0] r_au_res, r_mu_res;

    logic [7:0] r_op1, r_op2, r_op3, r_op4;
    logic       r_add_st, r_mul_st;
    logic [7:0] r_add_out, r_mul_out;
    logic [2:0] r_add_tag, r_mul_tag;

    logic [10:0] w_instr;
    logic [1:0]  w_op;
    logic [2:0]  w_rd, w_rs1, w_rs2;
    logic [10:0] w_s1, w_s2;
    logic        w_a_free_ok, w_m_free_ok, w_a_rdy_ok, w_m_rdy_ok;
    logic [1:0]  w_a_free_idx, w_a_rdy_idx;
    logic        w_m_free_idx, w_m_rdy_idx;
    logic        w_issue_add, w_issue_mul, w_a_start, w_m_start;
    logic [2:0]  w_new_tag;

    assign w_instr = rom_read(r_pc);
    assign w_op    = w_instr[10:9];
    assign w_rd    = w_instr[8:6];
    assign w_rs1   = w_instr[5:3];
    assign w_rs2   = w_instr[2:0];

    assign w_s1 = resolve(r_rtag[w_rs1], r_regs[w_rs1], r_add_st, r_add_tag, r_add_out,
                          r_mul_st, r_mul_tag, r_mul_out);
    assign w_s2 = resolve(r_rtag[w_rs2], r_regs[w_rs2], r_add_st, r_add_tag, r_add_out,
                          r_mul_st, r_mul_tag, r_mul_out);

    // Lowest-index free station (for issue) and lowest-index ready station (for dispatch).
    always_comb begin
        w_a_free_ok = 1'b0; w_a_free_idx = 2'd0;
        w_a_rdy_ok  = 1'b0; w_a_rdy_idx  = 2'd0;
        w_m_free_ok = 1'b0; w_m_free_idx = 1'b0;
        w_m_rdy_ok  = 1'b0; w_m_rdy_idx  = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!r_a_busy[i]) begin
                w_a_free_ok = 1'b1; w_a_free_idx = 2'(i);
            end
            if (r_a_busy[i] && !r_a_exec[i] && r_a_qj[i] == 3'd0 && r_a_qk[i] == 3'd0) begin
                w_a_rdy_ok = 1'b1; w_a_rdy_idx = 2'(i);
            end
        end
        for (int i = 1; i >= 0; i--) begin
            if (!r_m_busy[i]) begin
                w_m_free_ok = 1'b1; w_m_free_idx = 1'(i);
            end
            if (r_m_busy[i] && !r_m_exec[i] && r_m_qj[i] == 3'd0 && r_m_qk[i] == 3'd0) begin
                w_m_rdy_ok = 1'b1; w_m_rdy_idx = 1'(i);
            end
        end
    end

    assign w_issue_add = (w_op == OP_ADD || w_op == OP_SUB) && w_a_free_ok;
    assign w_issue_mul = (w_op == OP_MUL) && w_m_free_ok;
    assign w_new_tag   = w_issue_add ? (3'(w_a_free_idx) + 3'd1) : (3'(w_m_free_idx) + 3'd4);
    assign w_a_start   = !r_au_busy && w_a_rdy_ok;
    assign w_m_start   = !r_mu_busy && w_m_rdy_ok;

    // Cycle counter and in-order program counter (stalls on full RS class or HALT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt <= 5'd0;
            r_pc      <= 4'd0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 5'd1;
            if (w_issue_add || w_issue_mul) r_pc <= r_pc + 4'd1;
        end
    end

    // Register file: CDB writeback first, then issue claims rd with the new tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'(i + 1);
                r_rtag[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_add_st && r_rtag[i] == r_add_tag) begin
                    r_regs[i] <= r_add_out; r_rtag[i] <= 3'd0;
                end
                if (r_mul_st && r_rtag[i] == r_mul_tag) begin
                    r_regs[i] <= r_mul_out; r_rtag[i] <= 3'd0;
                end
            end
            if (w_issue_add || w_issue_mul) r_rtag[w_rd] <= w_new_tag;
        end
    end

    // Add reservation stations: free on own broadcast, capture operands, accept issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_busy <= 3'd0; r_a_exec <= 3'd0; r_a_sub <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                r_a_vj[i] <= 8'd0; r_a_vk[i] <= 8'd0;
                r_a_qj[i] <= 3'd0; r_a_qk[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_add_st && r_add_tag == 3'(i + 1)) begin
                    r_a_busy[i] <= 1'b0; r_a_exec[i] <= 1'b0;
                end
                if (w_a_start && w_a_rdy_idx == 2'(i)) r_a_exec[i] <= 1'b1;
                if (r_a_busy[i] && r_a_qj[i] != 3'd0) begin
                    if (r_add_st && r_a_qj[i] == r_add_tag) begin
                        r_a_vj[i] <= r_add_out; r_a_qj[i] <= 3'd0;
                    end else if (r_mul_st && r_a_qj[i] == r_mul_tag) begin
                        r_a_vj[i] <= r_mul_out; r_a_qj[i] <= 3'd0;
                    end
                end
                if (r_a_busy[i] && r_a_qk[i] != 3'd0) begin
                    if (r_add_st && r_a_qk[i] == r_add_tag) begin
                        r_a_vk[i] <= r_add_out; r_a_qk[i] <= 3'd0;
                    end else if (r_mul_st && r_a_qk[i] == r_mul_tag) begin
                        r_a_vk[i] <= r_mul_out; r_a_qk[i] <= 3'd0;
                    end
                end
                if (w_issue_add && w_a_free_idx == 2'(i)) begin
                    r_a_busy[i] <= 1'b1; r_a_exec[i] <= 1'b0;
                    r_a_sub[i]  <= (w_op == OP_SUB);
                    r_a_qj[i] <= w_s1[10:8]; r_a_vj[i] <= w_s1[7:0];
                    r_a_qk[i] <= w_s2[10:8]; r_a_vk[i] <= w_s2[7:0];
                end
            end
        end
    end

    // Mul reservation stations: same lifecycle as the add stations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_busy <= 2'd0; r_m_exec <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_m_vj[i] <= 8'd0; r_m_vk[i] <= 8'd0;
                r_m_qj[i] <= 3'd0; r_m_qk[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_mul_st && r_mul_tag == 3'(i + 4)) begin
                    r_m_busy[i] <= 1'b0; r_m_exec[i] <= 1'b0;
                end
                if (w_m_start && w_m_rdy_idx == 1'(i)) r_m_exec[i] <= 1'b1;
                if (r_m_busy[i] && r_m_qj[i] != 3'd0) begin
                    if (r_add_st && r_m_qj[i] == r_add_tag) begin
                        r_m_vj[i] <= r_add_out; r_m_qj[i] <= 3'd0;
                    end else if (r_mul_st && r_m_qj[i] == r_mul_tag) begin
                        r_m_vj[i] <= r_mul_out; r_m_qj[i] <= 3'd0;
                    end
                end
                if (r_m_busy[i] && r_m_qk[i] != 3'd0) begin
                    if (r_add_st && r_m_qk[i] == r_add_tag) begin
                        r_m_vk[i] <= r_add_out; r_m_qk[i] <= 3'd0;
                    end else if (r_mul_st && r_m_qk[i] == r_mul_tag) begin
                        r_m_vk[i] <= r_mul_out; r_m_qk[i] <= 3'd0;
                    end
                end
                if (w_issue_mul && w_m_free_idx == 1'(i)) begin
                    r_m_busy[i] <= 1'b1; r_m_exec[i] <= 1'b0;
                    r_m_qj[i] <= w_s1[10:8]; r_m_vj[i] <= w_s1[7:0];
                    r_m_qk[i] <= w_s2[10:8]; r_m_vk[i] <= w_s2[7:0];
                end
            end
        end
    end

    // Adder: count down the latency, then pulse the add CDB for one cycle;
    // the unit is idle again on the writeback edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_au_busy <= 1'b0; r_au_left <= 4'd0; r_au_idx <= 2'd0; r_au_res <= 8'd0;
            r_op1 <= 8'd0; r_op2 <= 8'd0;
            r_add_st <= 1'b0; r_add_out <= 8'd0; r_add_tag <= 3'd0;
        end else begin
            r_add_st <= 1'b0;
            if (r_au_busy) begin
                if (r_au_left == 4'd1) begin
                    r_au_busy <= 1'b0;
                    r_add_st  <= 1'b1;
                    r_add_out <= r_au_res;
                    r_add_tag <= 3'(r_au_idx) + 3'd1;
                end else begin
                    r_au_left <= r_au_left - 4'd1;
                end
            end else if (w_a_start) begin
                r_au_busy <= 1'b1;
                r_au_left <= 4'(ADD_LAT);
                r_au_idx  <= w_a_rdy_idx;
                r_au_res  <= alu(r_a_sub[w_a_rdy_idx], r_a_vj[w_a_rdy_idx], r_a_vk[w_a_rdy_idx]);
                r_op1     <= r_a_vj[w_a_rdy_idx];
                r_op2     <= r_a_vk[w_a_rdy_idx];
            end
        end
    end

    // Multiplier: same timing scheme as the adder with its own latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mu_busy <= 1'b0; r_mu_left <= 4'd0; r_mu_idx <= 1'b0; r_mu_res <= 8'd0;
            r_op3 <= 8'd0; r_op4 <= 8'd0;
            r_mul_st <= 1'b0; r_mul_out <= 8'd0; r_mul_tag <= 3'd0;
        end else begin
            r_mul_st <= 1'b0;
            if (r_mu_busy) begin
                if (r_mu_left == 4'd1) begin
                    r_mu_busy <= 1'b0;
                    r_mul_st  <= 1'b1;
                    r_mul_out <= r_mu_res;
                    r_mul_tag <= 3'(r_mu_idx) + 3'd4;
                end else begin
                    r_mu_left <= r_mu_left - 4'd1;
                end
            end else if (w_m_start) begin
                r_mu_busy <= 1'b1;
                r_mu_left <= 4'(MUL_LAT);
                r_mu_idx  <= w_m_rdy_idx;
                r_mu_res  <= mul8(r_m_vj[w_m_rdy_idx], r_m_vk[w_m_rdy_idx]);
                r_op3     <= r_m_vj[w_m_rdy_idx];
                r_op4     <= r_m_vk[w_m_rdy_idx];
            end
        end
    end

    assign count  = {2'b0, r_a_busy[0]} + {2'b0, r_a_busy[1]} + {2'b0, r_a_busy[2]};
    assign count2 = {2'b0, r_m_busy[0]} + {2'b0, r_m_busy[1]};

    assign clock_count = r_clk_cnt;
    assign Op1 = r_op1;
    assign Op2 = r_op2;
    assign Op3 = r_op3;
    assign Op4 = r_op4;
    assign ADD_Status = r_add_st;
    assign ADD_Output = r_add_out;
    assign ADD_Tag_op = r_add_tag;
    assign MUL_Status = r_mul_st;
    assign MUL_Output = r_mul_out;
    assign MUL_Tag_op = r_mul_tag;

endmodule

// File: tb/tb_tomasulo_core.sv
// Testbench for tomasulo_core: scoreboard of expected CDB broadcasts,
// occupancy and counter checks, and a mid-run asynchronous reset.
module tb_tomasulo_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] clock_count;
    logic [7:0] Op1, Op2, Op3, Op4;
    logic [2:0] count, count2;
    logic       ADD_Status, MUL_Status;
    logic [7:0] ADD_Output, MUL_Output;
    logic [2:0] ADD_Tag_op, MUL_Tag_op;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int edge_n;
        int val;
        int tag;
        int a;
        int b;
    } exp_t;

    exp_t q_add[$];
    exp_t q_mul[$];
    logic prev_add, prev_mul;

    tomasulo_core #(.ADD_LAT(2), .MUL_LAT(4), .PROG_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .clock_count(clock_count),
        .Op1(Op1), .Op2(Op2), .Op3(Op3), .Op4(Op4),
        .count(count), .count2(count2),
        .ADD_Status(ADD_Status), .ADD_Output(ADD_Output), .ADD_Tag_op(ADD_Tag_op),
        .MUL_Status(MUL_Status), .MUL_Output(MUL_Output), .MUL_Tag_op(MUL_Tag_op)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ops"}, {Op1, Op2, Op3, Op4}, 64'd0);
        check_eq({tag, "_misc"}, {clock_count, count, count2, ADD_Status, ADD_Output, ADD_Tag_op,
                                  MUL_Status, MUL_Output, MUL_Tag_op}, 64'd0);
    endtask

    // Run from reset release for n_edges edges; abort_edge>0 asserts rst_n just after that edge.
    task automatic run_prog(input int n_edges, input int abort_edge);
        exp_t x;
        q_add.delete();
        q_mul.delete();
        q_add.push_back('{4, 7, 1, 3, 4});
        q_add.push_back('{7, 5, 2, 8, 3});
        q_mul.push_back('{10, 42, 4, 7, 6});
        q_mul.push_back('{16, 126, 5, 42, 3});
        prev_add = 1'b0;
        prev_mul = 1'b0;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge clk);
            if (e == abort_edge) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort_clear");
                q_add.delete();
                q_mul.delete();
                return;
            end
            @(negedge clk);
            check_eq($sformatf("clock_count_e%0d", e), clock_count, 64'(e % 32));
            if (e == 1) check_eq("count_e1", count, 1);
            if (e == 2) check_eq("count2_e2", count2, 1);
            if (e == 4) check_eq("count2_e4", count2, 2);
            if (e == 17) check_eq("counts_e17", {count, count2}, 0);
            if (ADD_Status) begin
                check_eq("add_pulse_width", prev_add, 0);
                if (q_add.size() == 0) begin
                    check_eq("add_unexpected", 1, 0);
                end else begin
                    x = q_add.pop_front();
                    check_eq("add_edge", e, x.edge_n);
                    check_eq("add_out", ADD_Output, x.val);
                    check_eq("add_tag", ADD_Tag_op, x.tag);
                    check_eq("add_op1", Op1, x.a);
                    check_eq("add_op2", Op2, x.b);
                end
            end
            if (MUL_Status) begin
                check_eq("mul_pulse_width", prev_mul, 0);
                if (q_mul.size() == 0) begin
                    check_eq("mul_unexpected", 1, 0);
                end else begin
                    x = q_mul.pop_front();
                    check_eq("mul_edge", e, x.edge_n);
                    check_eq("mul_out", MUL_Output, x.val);
                    check_eq("mul_tag", MUL_Tag_op, x.tag);
                    check_eq("mul_op3", Op3, x.a);
                    check_eq("mul_op4", Op4, x.b);
                end
            end
            prev_add = ADD_Status;
            prev_mul = MUL_Status;
        end
        check_eq("add_missing", q_add.size(), 0);
        check_eq("mul_missing", q_mul.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        run_prog(40, 0);

        // Rerun from reset, abort mid-run, then check the timeline repeats.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_prog(20, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_after_abort");
        rst_n = 1'b1;
        run_prog(20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
